// File: rtl/blinky_pattern_rx.sv
// Serial LED-pattern receiver: bytes shifted in MSB first are stored in a small
// ring of pattern slots and played back on io_out at a prescaled rate.
module blinky_pattern_rx #(
  parameter int DEPTH    = 4,
  parameter int DIV_BASE = 10
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Wide enough for the slowest tick period, 2^(DIV_BASE+7) clocks.
  localparam int PW = DIV_BASE + 8;

  logic       clk;
  logic       rst_n;
  logic       sdata;
  logic       sen;
  logic [2:0] rate;
  logic       clr;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign sdata = io_in[2];
  assign sen   = io_in[3];
  assign rate  = io_in[6:4];
  assign clr   = io_in[7];

  logic [7:0]    shift_reg,  shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic [AW-1:0] rd_idx_reg, rd_idx_next;
  logic [PW-1:0] presc_reg,  presc_next;
  logic [2:0]    rate_reg;
  logic [7:0]    out_reg,    out_next;

  logic          byte_done;
  logic          wr_en;
  logic          rate_chg;
  logic          tick;
  logic [PW-1:0] presc_limit;

  logic [7:0] mem [DEPTH];

  // Receiver: a byte completes on the edge that samples its 8th bit.
  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    byte_done    = 1'b0;
    if (sen) begin
      shift_next   = {shift_reg[6:0], sdata};
      bit_cnt_next = bit_cnt_reg + 3'd1;
      byte_done    = (bit_cnt_reg == 3'd7);
    end else begin
      bit_cnt_next = 3'd0;
    end
    if (clr) begin
      bit_cnt_next = 3'd0;
    end
  end

  // A clear on the completing edge drops the byte entirely.
  assign wr_en = byte_done && !clr;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (clr) begin
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
      if (count_reg != CW'(DEPTH)) begin
        count_next = count_reg + CW'(1);
      end
    end
  end

  // Prescaler restarts whenever the rate select differs from last cycle's.
  assign rate_chg    = (rate != rate_reg);
  assign presc_limit = (PW'(1) << (DIV_BASE + int'(rate))) - PW'(1);
  assign tick        = !rate_chg && (presc_reg == presc_limit);

  always_comb begin
    presc_next = presc_reg + PW'(1);
    if (clr || rate_chg || tick) begin
      presc_next = '0;
    end
  end

  // Playback wrap uses the count from before any same-cycle write.
  always_comb begin
    rd_idx_next = rd_idx_reg;
    if (clr || count_reg == '0) begin
      rd_idx_next = '0;
    end else if (tick) begin
      if (CW'(rd_idx_reg) >= count_reg - CW'(1)) begin
        rd_idx_next = '0;
      end else begin
        rd_idx_next = rd_idx_reg + AW'(1);
      end
    end
  end

  always_comb begin
    out_next = 8'h00;
    if (count_reg != '0) begin
      out_next = mem[rd_idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_idx_reg  <= '0;
      presc_reg   <= '0;
      rate_reg    <= '0;
      out_reg     <= '0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      rd_idx_reg  <= rd_idx_next;
      presc_reg   <= presc_next;
      rate_reg    <= rate;
      out_reg     <= out_next;
    end
  end

  // Pattern storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= shift_next;
    end
  end

  assign io_out = out_reg;

endmodule

// File: tb/tb_blinky_pattern_rx.sv
// Directed bench for blinky_pattern_rx: table of single-byte loads plus
// hand-written playback, ring, clear-priority and async-reset sequences.
module tb_blinky_pattern_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdata = 1'b0;
  logic       sen = 1'b0;
  logic [2:0] rate = 3'd0;
  logic       clr = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks = 0;
  int failures = 0;

  assign io_in = {clr, rate, sen, sdata, rst_n, clk};

  blinky_pattern_rx #(.DEPTH(4), .DIV_BASE(10)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] prefix;
    int         plen;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shift the top n bits of b in MSB first, one per edge, then drop sen.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sen   = 1'b1;
      sdata = b[7-i];
      step();
    end
    sen   = 1'b0;
    sdata = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Step until io_out leaves old; a timeout counts as a failed check.
  task automatic wait_change(input logic [7:0] old, input int max_cyc, output int n);
    n = 0;
    while (io_out === old && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (io_out === old) begin
      failures++;
      $display("FAIL wait_change: io_out stuck at %02h for %0d cycles", old, n);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int elapsed;

    vecs[0] = '{8'h00, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'hF8, 5, 8'h3C, 8'h3C};
    vecs[2] = '{8'hFE, 7, 8'h81, 8'h81};
    vecs[3] = '{8'h00, 3, 8'h7E, 8'h7E};

    // Reset then a single byte, with sen rising as reset releases.
    repeat (3) step();
    check("reset_out", io_out, 8'h00);
    rst_n = 1'b1;
    send_bits(8'hA5, 8);
    check("a5_before", io_out, 8'h00);
    step();
    check("a5_after", io_out, 8'hA5);
    repeat (1100) step();
    check("a5_hold_across_tick", io_out, 8'hA5);
    $display("seq reset_single: io_out=%02h", io_out);

    // Table: optional aborted prefix, then one full byte; count must be 1.
    for (int v = 0; v < 4; v++) begin
      pulse_clr();
      if (vecs[v].plen > 0) begin
        send_bits(vecs[v].prefix, vecs[v].plen);
        step();
      end
      send_bits(vecs[v].data, 8);
      check($sformatf("vec%0d_before", v), io_out, 8'h00);
      step();
      check($sformatf("vec%0d_after", v), io_out, vecs[v].exp);
      repeat (1100) step();
      check($sformatf("vec%0d_hold", v), io_out, vecs[v].exp);
      $display("vec %0d: plen=%0d data=%02h io_out=%02h", v, vecs[v].plen, vecs[v].data, io_out);
    end

    // Playback cycling: first tick lands 1024 edges after the clear edge.
    pulse_clr();
    send_bits(8'h01, 8);
    send_bits(8'h02, 8);
    send_bits(8'h04, 8);
    elapsed = 24;
    check("cyc_first", io_out, 8'h01);
    wait_change(8'h01, 1100, n);
    check_int("cyc_first_time", elapsed + n, 1025);
    check("cyc_02", io_out, 8'h02);
    wait_change(8'h02, 1100, n);
    check_int("cyc_interval_1", n, 1024);
    check("cyc_04", io_out, 8'h04);
    wait_change(8'h04, 1100, n);
    check_int("cyc_interval_2", n, 1024);
    check("cyc_wrap_01", io_out, 8'h01);
    $display("seq playback_cycle: io_out=%02h", io_out);

    // Ring overwrite: fifth byte replaces slot 0.
    pulse_clr();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    send_bits(8'h55, 8);
    step();
    check("ring_slot0", io_out, 8'h55);
    wait_change(8'h55, 1100, n);
    check("ring_slot1", io_out, 8'h22);
    wait_change(8'h22, 1100, n);
    check("ring_slot2", io_out, 8'h33);
    wait_change(8'h33, 1100, n);
    check("ring_slot3", io_out, 8'h44);
    wait_change(8'h44, 1100, n);
    check("ring_wrap", io_out, 8'h55);
    $display("seq ring_overwrite: io_out=%02h", io_out);

    // Async reset between edges during playback, no clock edge involved.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", io_out, 8'h00);
    #1;
    rst_n = 1'b1;
    step();
    check("post_reset_out", io_out, 8'h00);
    repeat (1100) step();
    check("post_reset_hold", io_out, 8'h00);
    // Reset mid-frame aborts it; the next bit starts a new byte.
    send_bits(8'hF0, 4);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    send_bits(8'hC3, 8);
    step();
    check("midframe_reset_byte", io_out, 8'hC3);
    $display("seq async_reset: io_out=%02h", io_out);

    // Clear on the edge completing 0xFF while two bytes are stored.
    pulse_clr();
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    for (int i = 0; i < 7; i++) begin
      sen   = 1'b1;
      sdata = 1'b1;
      step();
    end
    clr = 1'b1;
    step();
    clr   = 1'b0;
    sen   = 1'b0;
    sdata = 1'b0;
    check("clr_edge_out", io_out, 8'h12);
    step();
    check("clr_next_out", io_out, 8'h00);
    repeat (1100) step();
    check("clr_byte_dropped", io_out, 8'h00);
    send_bits(8'h77, 8);
    step();
    check("clr_then_load", io_out, 8'h77);
    repeat (1100) step();
    check("clr_then_load_hold", io_out, 8'h77);
    $display("seq clear_priority: io_out=%02h", io_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
